mig_arb: RTL and testbench
==========================

Name: mig_arb

Overview:
- Two-port arbiter and sequencer in front of the DDR MIG user (app_*) interface.
- Port 0 is the CPU memory path and port 1 is the DMA/peripheral path.
- Grants one single-beat request at a time (128-bit line) and drives the MIG command and write-data handshakes.
- Routes returning read data to the originating port through an in-order tag FIFO.

Parameters:
- AW, 28, MIG app address width.
- DW, 128, data width of one MIG beat.
- MW, 16, byte-mask width (DW/8).
- RDQ_DEPTH, 4, maximum outstanding reads (tag FIFO depth, power of two).

Ports:
- mclk  in  1  MIG user clock; only clock.
- mrst  in  1  reset, asynchronous, active-high.
- p0_req  in  1  port 0 request; held with its fields until p0_ack.
- p0_we  in  1  port 0: 1=write, 0=read.
- p0_addr  in  AW  port 0 address.
- p0_wdata  in  DW  port 0 write data.
- p0_mask  in  MW  port 0 byte mask (1 = byte not written, MIG sense).
- p0_ack  out  1  one-cycle pulse: port 0 request accepted by MIG.
- p0_rvalid  out  1  read data on rd_data belongs to port 0.
- p1_req, p1_we, p1_addr, p1_wdata, p1_mask, p1_ack, p1_rvalid: same meanings for port 1.
- rd_data  out  DW  registered read data shared by both ports.
- rd_err  out  1  sticky: read data arrived with the tag FIFO empty.
- app_addr  out  AW  MIG address.
- app_cmd  out  3  MIG command: 000 write, 001 read.
- app_en  out  1  MIG command valid.
- app_rdy  in  1  MIG command accept.
- app_wdf_data  out  DW  MIG write data.
- app_wdf_mask  out  MW  MIG write mask.
- app_wdf_wren  out  1  MIG write-data valid.
- app_wdf_end  out  1  equal to app_wdf_wren (single beat).
- app_wdf_rdy  in  1  MIG write-data accept.
- app_rd_data  in  DW  MIG read data.
- app_rd_data_end  in  1  unused (single beat).
- app_rd_data_valid  in  1  MIG read-data valid.

Behaviour:
- Reset values: every output is 0 (app_en, app_wdf_wren, acks, rvalids, rd_data, rd_err, app_* buses). State is IDLE, the tag FIFO is empty, last_grant=1 so port 0 wins first.
- States: IDLE, WR, RD, ACK.
- IDLE arbitration:
  - An eligible port is one with req=1. A read request is eligible only if the tag FIFO is not full.
  - Round-robin: the port not equal to last_grant wins a tie.
  - On a grant, latch addr/we/wdata/mask into the app_* registers and set last_grant.
  - Go to WR (app_en=1, app_cmd=000, app_wdf_wren=1) or RD (app_en=1, app_cmd=001) on the next edge.
- WR state:
  - app_en drops on the cycle after app_en&app_rdy is sampled. app_wdf_wren drops independently on the cycle after app_wdf_wren&app_wdf_rdy.
  - Both may be accepted in either order or in the same cycle.
  - When both have been accepted, go to ACK.
- RD state: on app_en&app_rdy, drop app_en, push the granted port id into the tag FIFO in the same edge, then go to ACK.
- ACK state: pulse px_ack for the granted port for exactly one cycle, then go to IDLE. Requesters deassert or change req after seeing ack.
- Minimum latency, req to ack: req sampled in IDLE at cycle N, app_en high at N+1, accepted at N+1, ack at N+2. Next grant at N+3.
- Read return:
  - On app_rd_data_valid, register app_rd_data into rd_data. Pop the FIFO and pulse px_rvalid for the popped id one cycle later.
  - Push and pop in the same cycle are both honoured; the count is unchanged.
  - Valid data with the FIFO empty: drop it and set rd_err, which is cleared only by mrst.
- Reads complete out of band from the state machine. New grants continue while reads are outstanding.
- A full FIFO blocks only read grants; writes still proceed.
- Reset mid-operation: everything returns to its reset values immediately. In-flight MIG reads returning after reset hit an empty FIFO and set rd_err, which is the accepted behaviour.

Optional Feature:
- Macro MIG_ARB_PRIO_EN.
- Defined: fixed priority, port 0 always wins when eligible, and last_grant is ignored.
- Undefined: round-robin as described above.
- Everything else is identical.

Decomposition:
- Package mig_arb_pkg holds:
  - CMD_WRITE=3'b000 and CMD_READ=3'b001.
  - State encoding (IDLE/WR/RD/ACK).
  - Port id type (1 bit).
- Sub-module mig_tag_fifo: synchronous 1-bit-wide FIFO of depth RDQ_DEPTH with push, pop, full, empty and dout, reset by mrst.

Test Plan:
- Port 0 write, addr 0x0000100, data 0xA5 repeated, mask 0; app_rdy and app_wdf_rdy held 1. Expect app_cmd=000, app_en and app_wdf_wren each high for 1 cycle, p0_ack at N+2, no p1_ack.
- Both ports request reads on the same cycle from reset. Expect grants p0, p1, p0, p1 (round-robin); with MIG_ARB_PRIO_EN, all p0 grants until p0_req drops.
- Write with app_wdf_rdy late: app_rdy=1 immediately, app_wdf_rdy rises 3 cycles later. Expect app_en for 1 cycle, app_wdf_wren for 4 cycles, ack 1 cycle after the data is accepted.
- Five back-to-back port 1 reads, RDQ_DEPTH=4, no read data returned. Expect exactly 4 acks; the fifth is stalled. A port 0 write is still acked. After one app_rd_data_valid, the fifth read is granted.
- Reads issued in order p0, p1, p0; MIG returns data 0x1, 0x2, 0x3. Expect p0_rvalid with 0x1, p1_rvalid with 0x2, p0_rvalid with 0x3, each 1 cycle after the valid. A return coinciding with a push leaves the count correct.
- Issue a read, assert mrst before its data returns, then deliver app_rd_data_valid. Expect all outputs 0 during reset, no rvalid, and rd_err=1 afterwards.

Source files
------------

// File: rtl/mig_arb_pkg.sv
// mig_arb_pkg: shared MIG command codes, arbiter state encoding and port id type.
package mig_arb_pkg;
  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;
  typedef enum logic [1:0] {IDLE, WR, RD, ACK} state_t;
  typedef logic port_t;
endpackage

// File: rtl/mig_tag_fifo.sv
// mig_tag_fifo: in-order FIFO of port ids for outstanding MIG reads.
module mig_tag_fifo
  import mig_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  mclk,
  input  logic  mrst,
  input  logic  push,
  input  logic  pop,
  input  port_t din,
  output logic  full,
  output logic  empty,
  output port_t dout
);
  localparam int PW = $clog2(DEPTH);
  port_t mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (PW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rp];
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  always_ff @(posedge mclk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge mclk or posedge mrst)
    if (mrst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      cnt <= cnt + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
endmodule

// File: rtl/mig_arb.sv
// mig_arb: two-port arbiter/sequencer for the MIG app interface with in-order read return.
// Define MIG_ARB_PRIO_EN for fixed port-0 priority instead of round-robin.
module mig_arb
  import mig_arb_pkg::*;
#(
  parameter int AW = 28,
  parameter int DW = 128,
  parameter int MW = 16,
  parameter int RDQ_DEPTH = 4
) (
  input  logic          mclk,
  input  logic          mrst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  input  logic [MW-1:0] p0_mask,
  output logic          p0_ack,
  output logic          p0_rvalid,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  input  logic [MW-1:0] p1_mask,
  output logic          p1_ack,
  output logic          p1_rvalid,
  output logic [DW-1:0] rd_data,
  output logic          rd_err,
  output logic [AW-1:0] app_addr,
  output logic [2:0]    app_cmd,
  output logic          app_en,
  input  logic          app_rdy,
  output logic [DW-1:0] app_wdf_data,
  output logic [MW-1:0] app_wdf_mask,
  output logic          app_wdf_wren,
  output logic          app_wdf_end,
  input  logic          app_wdf_rdy,
  input  logic [DW-1:0] app_rd_data,
  input  logic          app_rd_data_end,
  input  logic          app_rd_data_valid
);
  state_t state;
  port_t gnt, last_grant, win, tag;
  logic full, empty, push, pop, e0, e1, we_sel, rd_end_unused;
  assign rd_end_unused = app_rd_data_end;
  assign e0 = p0_req & (p0_we | ~full);
  assign e1 = p1_req & (p1_we | ~full);
`ifdef MIG_ARB_PRIO_EN
  assign win = e0 ? 1'b0 : 1'b1;
`else
  assign win = (e0 & e1) ? ~last_grant : e1;
`endif
  assign we_sel = win ? p1_we : p0_we;
  assign push = (state == RD) & app_rdy;
  assign pop = app_rd_data_valid & ~empty;
  assign app_wdf_end = app_wdf_wren;

  mig_tag_fifo #(.DEPTH(RDQ_DEPTH)) u_fifo (
    .mclk(mclk), .mrst(mrst), .push(push), .pop(pop), .din(gnt),
    .full(full), .empty(empty), .dout(tag)
  );

  always_ff @(posedge mclk or posedge mrst)
    if (mrst) begin
      state <= IDLE;
      gnt <= 1'b0;
      last_grant <= 1'b1;
      app_addr <= '0;
      app_cmd <= '0;
      app_en <= 1'b0;
      app_wdf_data <= '0;
      app_wdf_mask <= '0;
      app_wdf_wren <= 1'b0;
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
    end else begin
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      case (state)
        IDLE: if (e0 | e1) begin
          gnt <= win;
          last_grant <= win;
          app_addr <= win ? p1_addr : p0_addr;
          app_wdf_data <= win ? p1_wdata : p0_wdata;
          app_wdf_mask <= win ? p1_mask : p0_mask;
          app_cmd <= we_sel ? CMD_WRITE : CMD_READ;
          app_en <= 1'b1;
          app_wdf_wren <= we_sel;
          state <= we_sel ? WR : RD;
        end
        WR: begin
          if (app_en & app_rdy) app_en <= 1'b0;
          if (app_wdf_wren & app_wdf_rdy) app_wdf_wren <= 1'b0;
          if ((~app_en | app_rdy) & (~app_wdf_wren | app_wdf_rdy)) begin
            state <= ACK;
            p0_ack <= ~gnt;
            p1_ack <= gnt;
          end
        end
        RD: if (app_rdy) begin
          app_en <= 1'b0;
          state <= ACK;
          p0_ack <= ~gnt;
          p1_ack <= gnt;
        end
        default: state <= IDLE;
      endcase
    end

  // Read data returning with no outstanding tag is dropped and flagged.
  always_ff @(posedge mclk or posedge mrst)
    if (mrst) begin
      rd_data <= '0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      rd_err <= 1'b0;
    end else begin
      p0_rvalid <= pop & ~tag;
      p1_rvalid <= pop & tag;
      if (pop) rd_data <= app_rd_data;
      if (app_rd_data_valid & empty) rd_err <= 1'b1;
    end
endmodule

// File: tb/tb_mig_arb.sv
// tb_mig_arb: directed stimulus with a transaction-level model checked every cycle.
module tb_mig_arb;
  localparam int AW = 28, DW = 128, MW = 16, RDQ = 4;
  logic mclk = 1'b0, mrst = 1'b0;
  logic p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
  logic [MW-1:0] p0_mask = '0, p1_mask = '0;
  logic p0_ack, p0_rvalid, p1_ack, p1_rvalid, rd_err, app_en, app_wdf_wren, app_wdf_end;
  logic [DW-1:0] rd_data, app_wdf_data;
  logic [AW-1:0] app_addr;
  logic [2:0] app_cmd;
  logic [MW-1:0] app_wdf_mask;
  logic app_rdy = 1, app_wdf_rdy = 1, app_rd_data_end = 0, app_rd_data_valid = 0;
  logic [DW-1:0] app_rd_data = '0;
  int n_cmp = 0, n_bad = 0;

  always #5 mclk = ~mclk;

  mig_arb #(.AW(AW), .DW(DW), .MW(MW), .RDQ_DEPTH(RDQ)) dut (
    .mclk(mclk), .mrst(mrst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_mask(p0_mask),
    .p0_ack(p0_ack), .p0_rvalid(p0_rvalid),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_mask(p1_mask),
    .p1_ack(p1_ack), .p1_rvalid(p1_rvalid),
    .rd_data(rd_data), .rd_err(rd_err),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_end(app_rd_data_end), .app_rd_data_valid(app_rd_data_valid)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Model: one command in flight, a queue of read owners, expected outputs per cycle.
  bit m_busy, m_ackc, m_rd, m_last, m_port;
  bit rdq[$];
  logic e_en, e_wren, e_ack0, e_ack1, e_rv0, e_rv1, e_err;
  logic [AW-1:0] e_addr;
  logic [2:0] e_cmd;
  logic [DW-1:0] e_wd, e_rd;
  logic [MW-1:0] e_mask;

  always @(posedge mclk or posedge mrst) begin : mdl
    int n;
    bit el0, el1, w, we;
    if (mrst) begin
      m_busy = 0; m_ackc = 0; m_rd = 0; m_last = 1; m_port = 0;
      rdq.delete();
      {e_en, e_wren, e_ack0, e_ack1, e_rv0, e_rv1, e_err} = '0;
      e_addr = '0; e_cmd = '0; e_wd = '0; e_rd = '0; e_mask = '0;
    end else begin
      n = rdq.size();
      e_ack0 = 0; e_ack1 = 0; e_rv0 = 0; e_rv1 = 0;
      if (app_rd_data_valid) begin
        if (n == 0) e_err = 1;
        else begin
          w = rdq.pop_front();
          e_rd = app_rd_data;
          if (w) e_rv1 = 1; else e_rv0 = 1;
        end
      end
      if (m_ackc) m_ackc = 0;
      else if (!m_busy) begin
        el0 = p0_req && (p0_we || n < RDQ);
        el1 = p1_req && (p1_we || n < RDQ);
        if (el0 || el1) begin
`ifdef MIG_ARB_PRIO_EN
          w = el0 ? 0 : 1;
`else
          if (el0 && el1) w = (m_last == 1) ? 0 : 1;
          else w = el0 ? 0 : 1;
`endif
          we = w ? p1_we : p0_we;
          m_busy = 1; m_port = w; m_last = w; m_rd = !we;
          e_en = 1; e_wren = we;
          e_cmd = we ? 3'b000 : 3'b001;
          e_addr = w ? p1_addr : p0_addr;
          e_wd = w ? p1_wdata : p0_wdata;
          e_mask = w ? p1_mask : p0_mask;
        end
      end else begin
        if (e_en && app_rdy) begin
          e_en = 0;
          if (m_rd) rdq.push_back(m_port);
        end
        if (e_wren && app_wdf_rdy) e_wren = 0;
        if (!e_en && !e_wren) begin
          m_busy = 0; m_ackc = 1;
          if (m_port) e_ack1 = 1; else e_ack0 = 1;
        end
      end
    end
  end

  always @(negedge mclk) begin
    chk("app_en", app_en, e_en);
    chk("app_wdf_wren", app_wdf_wren, e_wren);
    chk("app_wdf_end", app_wdf_end, e_wren);
    chk("app_cmd", app_cmd, e_cmd);
    chk("app_addr", app_addr, e_addr);
    chk("app_wdf_data", app_wdf_data, e_wd);
    chk("app_wdf_mask", app_wdf_mask, e_mask);
    chk("p0_ack", p0_ack, e_ack0);
    chk("p1_ack", p1_ack, e_ack1);
    chk("p0_rvalid", p0_rvalid, e_rv0);
    chk("p1_rvalid", p1_rvalid, e_rv1);
    chk("rd_data", rd_data, e_rd);
    chk("rd_err", rd_err, e_err);
  end

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic set_req(input bit p, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [MW-1:0] m);
    if (p) begin p1_req = 1; p1_we = we; p1_addr = a; p1_wdata = d; p1_mask = m; end
    else begin p0_req = 1; p0_we = we; p0_addr = a; p0_wdata = d; p0_mask = m; end
  endtask

  task automatic wait_ack(input bit p, output int cyc);
    cyc = 0;
    while (!(p ? p1_ack : p0_ack) && cyc < 30) begin tick(); cyc++; end
    chk($sformatf("ack%0d_wait", p), cyc < 30, 1);
  endtask

  task automatic ret(input logic [DW-1:0] d);
    app_rd_data = d;
    app_rd_data_valid = 1;
    tick();
    app_rd_data_valid = 0;
  endtask

  initial begin
    int c, na, ne, nw;
    bit g[$];
    #1 mrst = 1;
    repeat (3) @(posedge mclk);
    #1;
    chk("rst_app_en", app_en, 0);
    chk("rst_p0_ack", p0_ack, 0);
    chk("rst_rd_err", rd_err, 0);
    mrst = 0;
    tick();
    // single port-0 write, minimum latency
    set_req(0, 1, 28'h0000100, {16{8'hA5}}, '0);
    tick();
    chk("t1_en", app_en, 1);
    chk("t1_cmd", app_cmd, 3'b000);
    chk("t1_wren", app_wdf_wren, 1);
    chk("t1_addr", app_addr, 28'h0000100);
    tick();
    chk("t1_p0_ack", p0_ack, 1);
    chk("t1_p1_ack", p1_ack, 0);
    chk("t1_en_off", app_en, 0);
    chk("t1_wren_off", app_wdf_wren, 0);
    p0_req = 0;
    tick();
    chk("t1_ack_pulse", p0_ack, 0);
    // simultaneous reads from reset
    mrst = 1; tick(); mrst = 0;
    set_req(0, 0, 28'h200, '0, '0);
    set_req(1, 0, 28'h300, '0, '0);
    c = 0;
    while (g.size() < 4 && c < 60) begin
      tick(); c++;
      if (p0_ack) g.push_back(0);
      if (p1_ack) g.push_back(1);
    end
    p0_req = 0; p1_req = 0;
    chk("t2_grants", g.size(), 4);
    for (int i = 0; i < g.size(); i++)
`ifdef MIG_ARB_PRIO_EN
      chk($sformatf("t2_g%0d", i), g[i], 0);
`else
      chk($sformatf("t2_g%0d", i), g[i], i % 2);
`endif
    for (int i = 0; i < 4; i++) begin
      ret(DW'(i + 16));
      chk($sformatf("t2_rv%0d", i), p0_rvalid | p1_rvalid, 1);
    end
    // write with late write-data ready
    app_wdf_rdy = 0;
    set_req(1, 1, 28'h400, {4{32'hDEADBEEF}}, 16'h00F0);
    ne = 0; nw = 0; c = 0;
    while (!p1_ack && c < 30) begin
      tick(); c++;
      ne += int'(app_en);
      nw += int'(app_wdf_wren);
      if (nw == 4) app_wdf_rdy = 1;
    end
    p1_req = 0;
    app_wdf_rdy = 1;
    chk("t3_en_cycles", ne, 1);
    chk("t3_wren_cycles", nw, 4);
    chk("t3_ack_cycle", c, 5);
    chk("t3_wren_at_ack", app_wdf_wren, 0);
    tick();
    // tag FIFO fills; writes still go
    set_req(1, 0, 28'h500, '0, '0);
    na = 0;
    for (int i = 0; i < 40; i++) begin tick(); na += int'(p1_ack); end
    chk("t4_acks", na, 4);
    set_req(0, 1, 28'h600, {8{16'h1234}}, 16'hFF00);
    wait_ack(0, c);
    p0_req = 0;
    ret(128'h55);
    chk("t4_pop_rv", p1_rvalid, 1);
    wait_ack(1, c);
    p1_req = 0;
    for (int i = 0; i < 4; i++) ret(DW'(i + 32));
    tick();
    // in-order return with a pop coinciding with a push
    set_req(0, 0, 28'h700, '0, '0);
    wait_ack(0, c);
    p0_req = 0;
    set_req(1, 0, 28'h710, '0, '0);
    wait_ack(1, c);
    p1_req = 0;
    set_req(0, 0, 28'h720, '0, '0);
    c = 0;
    while (!app_en && c < 10) begin tick(); c++; end
    chk("t5_en", app_en, 1);
    ret(128'h1);
    chk("t5_rv_a", p0_rvalid, 1);
    chk("t5_d1", rd_data, 128'h1);
    chk("t5_ack", p0_ack, 1);
    p0_req = 0;
    ret(128'h2);
    chk("t5_rv_b", p1_rvalid, 1);
    chk("t5_d2", rd_data, 128'h2);
    ret(128'h3);
    chk("t5_rv_c", p0_rvalid, 1);
    chk("t5_d3", rd_data, 128'h3);
    ret(128'h4);
    chk("t5_empty_err", rd_err, 1);
    // reset with a read in flight
    mrst = 1; tick(); mrst = 0;
    chk("t6_err_clr", rd_err, 0);
    set_req(0, 0, 28'h800, '0, '0);
    wait_ack(0, c);
    p0_req = 0;
    mrst = 1;
    tick();
    chk("t6_rst_en", app_en, 0);
    chk("t6_rst_ack", p0_ack, 0);
    chk("t6_rst_addr", app_addr, 0);
    chk("t6_rst_data", rd_data, 0);
    tick();
    mrst = 0;
    ret(128'hBAD);
    chk("t6_no_rv0", p0_rvalid, 0);
    chk("t6_no_rv1", p1_rvalid, 0);
    chk("t6_err", rd_err, 1);
    tick();
    chk("t6_err_sticky", rd_err, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
